// File: rtl/tt_pad_pkg.sv
// rtl/tt_pad_pkg.sv - shared pad configuration constants and loader state encoding
package tt_pad_pkg;

    localparam int TT_PAD_CFG_W = 16;

    localparam logic [15:0] TT_PAD_NC       = 16'h0000;
    localparam logic [15:0] TT_PAD_IN       = 16'h0001;
    localparam logic [15:0] TT_PAD_OUT      = 16'h0002;
    localparam logic [15:0] TT_PAD_INOUT    = 16'h0003;
    localparam logic [15:0] TT_PAD_ANALOG   = 16'h0004;
    localparam logic [15:0] TT_PAD_PWR_CORE = 16'h0010;
    localparam logic [15:0] TT_PAD_GND_CORE = 16'h0011;
    localparam logic [15:0] TT_PAD_PWR_IO   = 16'h0012;
    localparam logic [15:0] TT_PAD_GND_IO   = 16'h0013;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } tt_pad_state_e;

endpackage

// File: rtl/tt_pad_cfg_shreg.sv
// rtl/tt_pad_cfg_shreg.sv - one config word shift register with bit-period divider
module tt_pad_cfg_shreg
    import tt_pad_pkg::*;
#(
    parameter int CFG_W     = TT_PAD_CFG_W,
    parameter int SHIFT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CFG_W-1:0] load_data,
    input  logic             en,
    output logic             sdo,
    output logic             shift,
    output logic             word_done
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam int BIT_W = $clog2(CFG_W + 1);

    logic [CFG_W-1:0] sreg_q, sreg_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q    <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            sreg_q    <= sreg_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The shift pulse lands on the last cycle of each bit period, so sdo is held for the whole period.
    always_comb begin
        sreg_d    = sreg_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift     = en && (div_cnt_q == DIV_W'(SHIFT_DIV - 1));
        word_done = shift && (bit_cnt_q == BIT_W'(CFG_W - 1));
        sdo       = en & sreg_q[CFG_W-1];
        if (load) begin
            sreg_d    = load_data;
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (en) begin
            if (shift) begin
                div_cnt_d = '0;
                sreg_d    = {sreg_q[CFG_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_pad_cfg_loader.sv
// rtl/tt_pad_cfg_loader.sv - sequences per-pad config words into the pad ring serial chain
module tt_pad_cfg_loader
    import tt_pad_pkg::*;
#(
    parameter int N_PADS     = 64,
    parameter int CFG_W      = TT_PAD_CFG_W,
    parameter int SHIFT_DIV  = 1,
    parameter int AUTO_START = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [$clog2(N_PADS)-1:0] cfg_addr,
    output logic                      cfg_rd,
    input  logic [CFG_W-1:0]          cfg_data,
    output logic                      pcfg_sdo,
    output logic                      pcfg_shift,
    output logic                      pcfg_latch,
    output logic                      busy,
    output logic                      cfg_valid
);

    localparam int AW = $clog2(N_PADS);
    localparam logic [AW-1:0] LAST_PAD = AW'(N_PADS - 1);

    tt_pad_state_e state_q, state_d;
    logic [AW-1:0] pad_idx_q, pad_idx_d;
    logic          pending_q, pending_d;
    logic          first_q, first_d;
    logic          valid_q, valid_d;
    logic          sh_load, sh_en, word_done;

    tt_pad_cfg_shreg #(
        .CFG_W    (CFG_W),
        .SHIFT_DIV(SHIFT_DIV)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .load_data(cfg_data),
        .en       (sh_en),
        .sdo      (pcfg_sdo),
        .shift    (pcfg_shift),
        .word_done(word_done)
    );

    // first_q marks the first cycle out of reset so AUTO_START fires exactly once per reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pad_idx_q <= '0;
            pending_q <= 1'b0;
            first_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pad_idx_q <= pad_idx_d;
            pending_q <= pending_d;
            first_q   <= first_d;
            valid_q   <= valid_d;
        end
    end

    // cfg_valid rises together with pcfg_latch and drops on the FETCH of the top pad.
    always_comb begin
        state_d    = state_q;
        pad_idx_d  = pad_idx_q;
        pending_d  = pending_q;
        first_d    = 1'b0;
        valid_d    = valid_q;
        cfg_rd     = 1'b0;
        pcfg_latch = 1'b0;
        sh_load    = 1'b0;
        sh_en      = 1'b0;
        if (state_q != ST_IDLE) begin
            pending_d = pending_q | start;
        end
        case (state_q)
            ST_IDLE: begin
                if (start || ((AUTO_START != 0) && first_q)) begin
                    state_d   = ST_FETCH;
                    pad_idx_d = LAST_PAD;
                    valid_d   = 1'b0;
                end
            end
            ST_FETCH: begin
                cfg_rd  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sh_load = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_en = 1'b1;
                if (word_done) begin
                    if (pad_idx_q == '0) begin
                        state_d = ST_LATCH;
                        valid_d = 1'b1;
                    end else begin
                        pad_idx_d = pad_idx_q - 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_LATCH: begin
                pcfg_latch = 1'b1;
                pending_d  = 1'b0;
                if (pending_q || start) begin
                    state_d   = ST_FETCH;
                    pad_idx_d = LAST_PAD;
                    valid_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cfg_addr  = pad_idx_q;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_valid = valid_q;

endmodule

// File: doc/tt_pad_cfg_loader.md
Name: tt_pad_cfg_loader

Overview:
Sequencer that loads the per-pad configuration words into the pad ring's serial configuration chain after reset, or on request. It reads one CFG_W-bit word per pad from an external config table and shifts all N_PADS words out bit-serially. It then pulses a latch strobe so all pads update at once. It sits between tt_top housekeeping and the pad ring, replacing hard-wired per-pad configuration with a runtime-reloadable chain.

Parameters:
N_PADS, 64, number of pads in the chain
CFG_W, 16, config bits per pad
SHIFT_DIV, 1, clk cycles per shift bit (>=1); pcfg_shift asserts on the last cycle of each period
AUTO_START, 1, if 1, a load begins automatically on the first cycle after reset release

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request a (re)load; level-sampled each cycle
cfg_addr  out  clog2(N_PADS)  config table read address (pad index)
cfg_rd  out  1  read strobe; cfg_data is valid the cycle after cfg_rd
cfg_data  in  CFG_W  config word for pad cfg_addr
pcfg_sdo  out  1  serial chain data
pcfg_shift  out  1  one-cycle shift enable for the chain
pcfg_latch  out  1  one-cycle update strobe; pads adopt the shifted config
busy  out  1  load in progress
cfg_valid  out  1  high after a completed load until the next load begins

Behaviour:
- Reset (async): state=IDLE; all outputs 0; pending=0; counters=0; sreg=0.
- States:
  - IDLE: enter FETCH on start, or when AUTO_START=1 and this is the first cycle after reset.
  - FETCH: cfg_addr=pad_idx, cfg_rd=1, for 1 cycle -> LOAD.
  - LOAD: sreg<=cfg_data, bit_cnt<=0 -> SHIFT.
  - SHIFT: pcfg_sdo=sreg[CFG_W-1] for the whole bit period. On the last cycle of each SHIFT_DIV period, pcfg_shift=1, sreg<<=1 and bit_cnt++.
  - After bit CFG_W-1 is shifted: if pad_idx==0 -> LATCH, else pad_idx-- and -> FETCH.
  - LATCH: pcfg_latch=1 for 1 cycle; cfg_valid<=1. Then -> FETCH with pad_idx=N_PADS-1 if pending (clear pending), else -> IDLE.
- Load order: pad_idx starts at N_PADS-1 and counts down to 0. Bits go MSB first, so pad 0's LSB is the last bit shifted.
- Cycles per load: N_PADS*(2+CFG_W*SHIFT_DIV)+1 from the FETCH entry to the end of LATCH. With defaults this is 64*18+1=1153.
- busy=1 in FETCH/LOAD/SHIFT/LATCH.
- cfg_valid clears on the cycle FETCH is entered for pad N_PADS-1.
- start while busy (including during LATCH): sets pending. Multiple starts collapse to a single reload, and the current load is never aborted.
- start held high in IDLE: one load per rising detection is not required. While start stays high, loads repeat back-to-back through the pending mechanism.
- pcfg_shift is never asserted in FETCH, LOAD, LATCH or IDLE. The chain tolerates the 2-cycle inter-word gaps.
- Bit counter is clog2(CFG_W+1) wide. The divider counter wraps at SHIFT_DIV-1 and resets to 0 on entering SHIFT.
- Reset mid-load: the chain contents are undefined but pcfg_latch is never issued, so the pads keep their previous config. The next load is triggered by start or AUTO_START.

Decomposition:
- Shared package tt_pad_pkg holds:
  - CFG_W.
  - Pad mode encodings TT_PAD_NC, IN, OUT, INOUT, ANALOG, PWR/GND_CORE, PWR/GND_IO as 16-bit constants.
  - The FSM state enum.
- One sub-module, tt_pad_cfg_shreg, holds the CFG_W shift register, SHIFT_DIV divider and bit counter. It has a load/start input and a word_done output.
- The FSM and pad counter stay in tt_pad_cfg_loader.

Test Plan:
- Reset release, AUTO_START=1, table[i]=16'h000A for all i -> busy rises next cycle; exactly 1024 pcfg_shift pulses and 1 pcfg_latch; cfg_valid=1 at cycle 1153.
- Table[i]={8'(i),8'(~i)}, capture the chain into a 1024-bit model -> pad 63 word first, MSB first; the final 16 bits equal 16'h00FF (pad 0).
- SHIFT_DIV=4 -> pcfg_shift period 4 cycles, sdo stable across each period; load takes 64*66+1=4225 cycles.
- start pulsed 3 times mid-load -> exactly one additional load follows LATCH directly (FETCH of pad 63 the next cycle); cfg_valid drops then reasserts.
- rst asserted during SHIFT of pad 20 -> all outputs 0 immediately, no pcfg_latch seen; a later start performs a full 1153-cycle load.
- AUTO_START=0, start held low -> no cfg_rd or shift activity for 2000 cycles; busy=0, cfg_valid=0.
